// File: rtl/jk_pkg.sv
// jk_pkg -- shared types and constants for the JK excitation generator.
//   state_t   : FSM state encoding (IDLE, DRIVE, CHECK)
//   JK_*      : 2-bit {j,k} excitation codes (HOLD, SET, RESET, TOGGLE)
//   HCNT_W    : width of the DRIVE hold down-counter (HOLD_CYCLES up to 255)
package jk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  // Excitation codes packed as {j,k}
  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  localparam int HCNT_W = 8;

endpackage

// File: rtl/jk_excite_lut.sv
// jk_excite_lut -- combinational JK excitation table.
//   cur_q : present flip-flop state
//   tgt_q : requested next state
//   jk    : {j,k} excitation that moves cur_q to tgt_q
// Build option: JK_TOGGLE_EN selects toggle (j1 k1) for every state change
// instead of separate set (j1 k0) / reset (j0 k1); holds are j0 k0 either way.
module jk_excite_lut
  import jk_pkg::*;
(
  input  logic       cur_q,
  input  logic       tgt_q,
  output logic [1:0] jk
);

`ifdef JK_TOGGLE_EN
  always_comb begin
    jk = JK_HOLD;
    if (cur_q != tgt_q) jk = JK_TOGGLE;
  end
`else
  always_comb begin
    jk = JK_HOLD;
    if (cur_q != tgt_q) jk = tgt_q ? JK_SET : JK_RESET;
  end
`endif

endmodule

// File: rtl/jk_excite_gen.sv
// jk_excite_gen -- drives a JK flip-flop toward a requested state and checks it.
//   clk, rst_n           : clock, asynchronous active-low reset
//   tgt_valid/tgt_ready  : handshake for a requested next state tgt_q
//   q_fb                 : observed q of the driven flip-flop
//   j, k                 : registered excitation outputs
//   busy                 : high while driving or checking
//   err                  : one-cycle pulse after a failed check
//   err_cnt              : saturating count of failed checks
// Parameters: HOLD_CYCLES (1..255) cycles j/k are held, CNT_W error counter width.
// Build option: JK_TOGGLE_EN (see jk_excite_lut).
module jk_excite_gen
  import jk_pkg::*;
#(
  parameter int HOLD_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tgt_valid,
  input  logic             tgt_q,
  output logic             tgt_ready,
  input  logic             q_fb,
  output logic             j,
  output logic             k,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);

  state_t            state;
  logic              cur_q;
  logic              tgt_r;
  logic [HCNT_W-1:0] hold_cnt;
  logic [1:0]        lut_jk;

  jk_excite_lut u_lut (
    .cur_q (cur_q),
    .tgt_q (tgt_r),
    .jk    (lut_jk)
  );

  // Because j/k are registered from the state, the first DRIVE cycle still
  // shows HOLD; the excitation then appears for exactly HOLD_CYCLES cycles,
  // giving an accept-to-IDLE latency of HOLD_CYCLES+2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cur_q     <= 1'b0;
      tgt_r     <= 1'b0;
      hold_cnt  <= '0;
      j         <= 1'b0;
      k         <= 1'b0;
      busy      <= 1'b0;
      tgt_ready <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          cur_q     <= q_fb;
          {j, k}    <= JK_HOLD;
          busy      <= 1'b0;
          tgt_ready <= 1'b1;
          // tgt_ready is still low on the first edge after reset release,
          // so no transfer can happen before it is visible.
          if (tgt_valid && tgt_ready) begin
            tgt_r     <= tgt_q;
            hold_cnt  <= HCNT_W'(HOLD_CYCLES);
            state     <= ST_DRIVE;
            busy      <= 1'b1;
            tgt_ready <= 1'b0;
          end
        end
        ST_DRIVE: begin
          if (hold_cnt != '0) begin
            {j, k}   <= lut_jk;
            hold_cnt <= hold_cnt - 1'b1;
          end else begin
            {j, k} <= JK_HOLD;
            state  <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          {j, k}    <= JK_HOLD;
          state     <= ST_IDLE;
          busy      <= 1'b0;
          tgt_ready <= 1'b1;
          if (q_fb != tgt_r) begin
            err <= 1'b1;
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
          end
        end
        default: begin
          {j, k}    <= JK_HOLD;
          state     <= ST_IDLE;
          busy      <= 1'b0;
          tgt_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
